// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b datapath types.
//   lc3b_word          : 16-bit machine word
//   lc3b_reg           : 3-bit architectural register index
//   lc3b_wb_entry      : one writeback request {dest, data}
//   WBQ_DEPTH_DEFAULT  : default writeback queue depth
// ---------------------------------------------------------------------------
package lc3b_types;

    localparam int WBQ_DEPTH_DEFAULT = 4;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef struct packed {
        lc3b_reg  dest;
        lc3b_word data;
    } lc3b_wb_entry;

endpackage

// File: rtl/wbq_onehot_dec.sv
// ---------------------------------------------------------------------------
// wbq_onehot_dec
// Register index to one-hot decoder, used to build the pending mask.
// Ports:
//   idx     in   $clog2(NREG)  register index
//   onehot  out  NREG          bit idx set, all others clear
// ---------------------------------------------------------------------------
module wbq_onehot_dec #(
    parameter int NREG = 8
) (
    input  logic [$clog2(NREG)-1:0] idx,
    output logic [NREG-1:0]         onehot
);

    assign onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
// Writeback buffer in front of the LC-3b register file's single write port.
// Accepts requests from the memory-load path (fixed priority) and the ALU,
// queues them in acceptance order and drains one per granted cycle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   alu_valid/ready/dest/data  ALU writeback handshake
//   mem_valid/ready/dest/data  memory-load writeback handshake
//   rf_grant                   regfile write port available this cycle
//   rf_load/dest/data          regfile write port drive (head entry)
//   pending                    bit r set while any queued entry targets r
//   count                      current occupancy (0..DEPTH)
// Optional (macro WBQ_FWD_EN):
//   fwd_src_a/b   in   register to look up
//   fwd_hit_a/b   out  youngest queued entry targets that register
//   fwd_data_a/b  out  that entry's data, 0 when no hit
// ---------------------------------------------------------------------------
module regfile_wb_queue
    import lc3b_types::*;
#(
    parameter int DEPTH  = WBQ_DEPTH_DEFAULT,
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [$clog2(NREG)-1:0]    alu_dest,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [$clog2(NREG)-1:0]    mem_dest,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       rf_grant,
    output logic                       rf_load,
    output logic [$clog2(NREG)-1:0]    rf_dest,
    output logic [DATA_W-1:0]          rf_data,
    output logic [NREG-1:0]            pending,
`ifdef WBQ_FWD_EN
    input  logic [$clog2(NREG)-1:0]    fwd_src_a,
    input  logic [$clog2(NREG)-1:0]    fwd_src_b,
    output logic                       fwd_hit_a,
    output logic                       fwd_hit_b,
    output logic [DATA_W-1:0]          fwd_data_a,
    output logic [DATA_W-1:0]          fwd_data_b,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REG_W = $clog2(NREG);

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DEPTH-1:0]  valid_q;
    logic [REG_W-1:0]  dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [NREG-1:0]   dest_oh [DEPTH];

    logic              not_full;
    logic              push;
    logic              pop;
    logic [REG_W-1:0]  push_dest;
    logic [DATA_W-1:0] push_data;

    // Ready is a function of registered occupancy only, so a pop in the
    // same cycle never opens a slot early; it is also held low in reset.
    assign not_full  = (count < CNT_W'(DEPTH));
    assign mem_ready = rst_n && not_full;
    assign alu_ready = rst_n && not_full && !mem_valid;

    assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push_dest = mem_valid ? mem_dest : alu_dest;
    assign push_data = mem_valid ? mem_data : alu_data;

    assign rf_load = (count != '0) && rf_grant;
    assign pop     = rf_load;
    assign rf_dest = (count != '0) ? dest_q[rd_ptr] : '0;
    assign rf_data = (count != '0) ? data_q[rd_ptr] : '0;

    // Control state: pointers, occupancy and per-entry valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage: no reset, occupancy is tracked by valid_q/count.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= push_dest;
            data_q[wr_ptr] <= push_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_dec
        wbq_onehot_dec #(.NREG(NREG)) u_dec (
            .idx    (dest_q[i]),
            .onehot (dest_oh[i])
        );
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending = pending | dest_oh[i];
            end
        end
    end

`ifdef WBQ_FWD_EN
    // Walk from the head (oldest) toward the tail; later matches overwrite
    // earlier ones so the youngest matching entry wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        idx        = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (valid_q[idx] && (dest_q[idx] == fwd_src_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = data_q[idx];
            end
            if (valid_q[idx] && (dest_q[idx] == fwd_src_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = data_q[idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [2:0]  alu_dest = '0;
    logic [15:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [2:0]  mem_dest = '0;
    logic [15:0] mem_data = '0;
    logic        rf_grant = 1'b0;
    logic        rf_load;
    logic [2:0]  rf_dest;
    logic [15:0] rf_data;
    logic [7:0]  pending;
    logic [2:0]  count;
`ifdef WBQ_FWD_EN
    logic [2:0]  fwd_src_a = '0;
    logic [2:0]  fwd_src_b = '0;
    logic        fwd_hit_a;
    logic        fwd_hit_b;
    logic [15:0] fwd_data_a;
    logic [15:0] fwd_data_b;
`endif

    int npass  = 0;
    int ntotal = 0;

    regfile_wb_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_dest   (alu_dest),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_dest   (mem_dest),
        .mem_data   (mem_data),
        .rf_grant   (rf_grant),
        .rf_load    (rf_load),
        .rf_dest    (rf_dest),
        .rf_data    (rf_data),
        .pending    (pending),
`ifdef WBQ_FWD_EN
        .fwd_src_a  (fwd_src_a),
        .fwd_src_b  (fwd_src_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
`endif
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        av;
        logic [2:0]  ad;
        logic [15:0] adat;
        logic        mv;
        logic [2:0]  md;
        logic [15:0] mdat;
        logic        g;
        logic        e_load;
        logic [2:0]  e_dest;
        logic [15:0] e_data;
        logic        e_ardy;
        logic        e_mrdy;
        logic [7:0]  e_pend;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(logic av, logic [2:0] ad, logic [15:0] adat,
                                logic mv, logic [2:0] md, logic [15:0] mdat, logic g,
                                logic el, logic [2:0] ed, logic [15:0] edat,
                                logic ea, logic em, logic [7:0] ep, logic [2:0] ec);
        vec_t v;
        v.av = av; v.ad = ad; v.adat = adat;
        v.mv = mv; v.md = md; v.mdat = mdat; v.g = g;
        v.e_load = el; v.e_dest = ed; v.e_data = edat;
        v.e_ardy = ea; v.e_mrdy = em; v.e_pend = ep; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            npass++;
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] ad, input logic [15:0] adat,
                         input logic mv, input logic [2:0] md, input logic [15:0] mdat,
                         input logic g);
        @(negedge clk);
        alu_valid = av; alu_dest = ad; alu_data = adat;
        mem_valid = mv; mem_dest = md; mem_data = mdat;
        rf_grant  = g;
        #1;
    endtask

    task automatic chk_port(input string tag, input logic el, input logic [2:0] ed,
                            input logic [15:0] edat, input logic [7:0] ep, input logic [2:0] ec);
        chk({tag, ".rf_load"}, 32'(rf_load), 32'(el));
        chk({tag, ".rf_dest"}, 32'(rf_dest), 32'(ed));
        chk({tag, ".rf_data"}, 32'(rf_data), 32'(edat));
        chk({tag, ".pending"}, 32'(pending), 32'(ep));
        chk({tag, ".count"},   32'(count),   32'(ec));
    endtask

    initial begin
        // single ALU write, then R3 drains
        vecs[0]  = mk(1,3,16'h1234, 0,0,16'h0000, 1,  0,0,16'h0000, 1,1,8'h00,0);
        vecs[1]  = mk(0,0,16'h0000, 0,0,16'h0000, 1,  1,3,16'h1234, 1,1,8'h08,1);
        vecs[2]  = mk(0,0,16'h0000, 0,0,16'h0000, 1,  0,0,16'h0000, 1,1,8'h00,0);
        // memory priority over ALU, drain R1 then R2
        vecs[3]  = mk(1,2,16'h5555, 1,1,16'hAAAA, 0,  0,0,16'h0000, 0,1,8'h00,0);
        vecs[4]  = mk(1,2,16'h5555, 0,0,16'h0000, 0,  0,1,16'hAAAA, 1,1,8'h02,1);
        vecs[5]  = mk(0,0,16'h0000, 0,0,16'h0000, 1,  1,1,16'hAAAA, 1,1,8'h06,2);
        vecs[6]  = mk(0,0,16'h0000, 0,0,16'h0000, 1,  1,2,16'h5555, 1,1,8'h04,1);
        vecs[7]  = mk(0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 1,1,8'h00,0);
        // WAW on R5: 0001 then 0002, pending[5] held until second pop
        vecs[8]  = mk(1,5,16'h0001, 0,0,16'h0000, 0,  0,0,16'h0000, 1,1,8'h00,0);
        vecs[9]  = mk(1,5,16'h0002, 0,0,16'h0000, 0,  0,5,16'h0001, 1,1,8'h20,1);
        vecs[10] = mk(0,0,16'h0000, 0,0,16'h0000, 1,  1,5,16'h0001, 1,1,8'h20,2);
        vecs[11] = mk(0,0,16'h0000, 0,0,16'h0000, 1,  1,5,16'h0002, 1,1,8'h20,1);
        vecs[12] = mk(0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 1,1,8'h00,0);

        // reset state, grant high must not produce a load
        rf_grant = 1'b1;
        #2;
        chk("rst.alu_ready", 32'(alu_ready), 32'd0);
        chk("rst.mem_ready", 32'(mem_ready), 32'd0);
        chk_port("rst", 0, 0, 16'h0000, 8'h00, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rf_grant = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].adat,
                  vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].g);
            chk($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ardy));
            chk($sformatf("vec%0d.mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mrdy));
            chk_port($sformatf("vec%0d", i), vecs[i].e_load, vecs[i].e_dest,
                     vecs[i].e_data, vecs[i].e_pend, vecs[i].e_cnt);
        end

        // full / backpressure: 5 pushes with no grant, pointers start mid-ring
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'(i), 16'hC000 + 16'(i), 0, 0, 16'h0000, 0);
            chk($sformatf("full%0d.alu_ready", i), 32'(alu_ready), 32'(i < 4));
            chk($sformatf("full%0d.mem_ready", i), 32'(mem_ready), 32'(i < 4));
            chk($sformatf("full%0d.count", i), 32'(count), 32'(i));
        end
        // first pop at full: ready stays low this cycle
        drive(1, 3'd4, 16'hC004, 0, 0, 16'h0000, 1);
        chk("drain0.alu_ready", 32'(alu_ready), 32'd0);
        chk("drain0.mem_ready", 32'(mem_ready), 32'd0);
        chk_port("drain0", 1, 0, 16'hC000, 8'h0F, 4);
        // ready returns; held R4 request is accepted alongside the pop
        drive(1, 3'd4, 16'hC004, 0, 0, 16'h0000, 1);
        chk("drain1.alu_ready", 32'(alu_ready), 32'd1);
        chk_port("drain1", 1, 1, 16'hC001, 8'h0E, 3);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
        chk_port("drain2", 1, 2, 16'hC002, 8'h1C, 3);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
        chk_port("drain3", 1, 3, 16'hC003, 8'h18, 2);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
        chk_port("drain4", 1, 4, 16'hC004, 8'h10, 1);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
        chk_port("drain5", 0, 0, 16'h0000, 8'h00, 0);

`ifdef WBQ_FWD_EN
        // forwarding: youngest of two R4 entries wins, R6 misses
        drive(1, 3'd4, 16'h00FF, 0, 0, 16'h0000, 0);
        drive(1, 3'd4, 16'hBEEF, 0, 0, 16'h0000, 0);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        fwd_src_a = 3'd4;
        fwd_src_b = 3'd6;
        #1;
        chk("fwd.hit_a",  32'(fwd_hit_a),  32'd1);
        chk("fwd.data_a", 32'(fwd_data_a), 32'hBEEF);
        chk("fwd.hit_b",  32'(fwd_hit_b),  32'd0);
        chk("fwd.data_b", 32'(fwd_data_b), 32'h0000);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        chk("fwd.empty_count", 32'(count), 32'd0);
`endif

        // reset mid-burst with 3 entries queued
        drive(1, 3'd6, 16'h6666, 0, 0, 16'h0000, 0);
        drive(0, 0, 16'h0000, 1, 3'd7, 16'h7777, 0);
        drive(1, 3'd0, 16'h0A0A, 0, 0, 16'h0000, 0);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
        chk_port("preRst", 1, 6, 16'h6666, 8'hC1, 3);
        rst_n = 1'b0;
        #1;
        chk("midRst.alu_ready", 32'(alu_ready), 32'd0);
        chk("midRst.mem_ready", 32'(mem_ready), 32'd0);
        chk_port("midRst", 0, 0, 16'h0000, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postRst.alu_ready", 32'(alu_ready), 32'd1);
        chk("postRst.mem_ready", 32'(mem_ready), 32'd1);
        chk_port("postRst", 0, 0, 16'h0000, 8'h00, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
